// File: rtl/estagio_alu_sinc_param.sv
// Clocked NULL/DATA ALU stage with a return-to-zero handshake, stall watchdog and token counter.
// Define ALU_SATURACAO_EN to clamp overflowing ADD/SUB results instead of wrapping them.
module estagio_alu_sinc_param #(
    parameter int unsigned LARGURA        = 8,
    parameter int unsigned LIMITE_ESPERA  = 0,
    parameter int unsigned LARGURA_TOKENS = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [LARGURA-1:0]        a,
    input  logic [LARGURA-1:0]        b,
    input  logic [2:0]                opr,
    input  logic                      ack_in,
    output logic [LARGURA-1:0]        resultado,
    output logic [1:0]                of,
    output logic [1:0]                neg,
    output logic [1:0]                zero,
    output logic                      ack_out,
    output logic                      erro,
    output logic                      timeout,
    output logic [LARGURA_TOKENS-1:0] tokens
);

    typedef enum logic {StVazio, StCheio} estado_e;

    localparam logic [1:0] DrNull  = 2'b00;
    localparam logic [1:0] DrFalso = 2'b01;
    localparam logic [1:0] DrVerd  = 2'b10;

    localparam int unsigned LARG_ESP = (LIMITE_ESPERA > 0) ? $clog2(LIMITE_ESPERA + 1) : 1;
    localparam logic [LARG_ESP-1:0] LIMITE_W = LARG_ESP'(LIMITE_ESPERA);

    estado_e                   estado_q, estado_d;
    logic [LARGURA-1:0]        res_q, res_d;
    logic [1:0]                of_q, of_d;
    logic [1:0]                neg_q, neg_d;
    logic [1:0]                zero_q, zero_d;
    logic                      ack_out_q, ack_out_d;
    logic                      erro_q, erro_d;
    logic                      timeout_q, timeout_d;
    logic [LARGURA_TOKENS-1:0] tokens_q, tokens_d;
    logic [LARG_ESP-1:0]       espera_q, espera_d;

    logic [LARGURA:0]   soma_ext, dif_ext;
    logic [LARGURA-1:0] alu_res;
    logic               alu_ovf;

    assign soma_ext = {a[LARGURA-1], a} + {b[LARGURA-1], b};
    assign dif_ext  = {a[LARGURA-1], a} - {b[LARGURA-1], b};

    // Overflow whenever the extended sign bit disagrees with the truncated MSB;
    // the extended sign bit also tells the direction for saturation.
    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        unique case (opr)
            3'b001: begin
                alu_ovf = soma_ext[LARGURA] ^ soma_ext[LARGURA-1];
`ifdef ALU_SATURACAO_EN
                alu_res = alu_ovf ? {soma_ext[LARGURA], {(LARGURA-1){~soma_ext[LARGURA]}}}
                                  : soma_ext[LARGURA-1:0];
`else
                alu_res = soma_ext[LARGURA-1:0];
`endif
            end
            3'b010: begin
                alu_ovf = dif_ext[LARGURA] ^ dif_ext[LARGURA-1];
`ifdef ALU_SATURACAO_EN
                alu_res = alu_ovf ? {dif_ext[LARGURA], {(LARGURA-1){~dif_ext[LARGURA]}}}
                                  : dif_ext[LARGURA-1:0];
`else
                alu_res = dif_ext[LARGURA-1:0];
`endif
            end
            3'b011:  alu_res = a & b;
            3'b100:  alu_res = a | b;
            3'b101:  alu_res = a ^ b;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        estado_d  = estado_q;
        res_d     = res_q;
        of_d      = of_q;
        neg_d     = neg_q;
        zero_d    = zero_q;
        ack_out_d = ack_out_q;
        erro_d    = erro_q;
        timeout_d = timeout_q;
        tokens_d  = tokens_q;
        espera_d  = espera_q;
        unique case (estado_q)
            StVazio: begin
                if (opr != 3'b000 && ack_in) begin
                    estado_d  = StCheio;
                    res_d     = alu_res;
                    of_d      = alu_ovf ? DrVerd : DrFalso;
                    neg_d     = alu_res[LARGURA-1] ? DrVerd : DrFalso;
                    zero_d    = (alu_res == '0) ? DrVerd : DrFalso;
                    ack_out_d = 1'b0;
                    tokens_d  = tokens_q + 1'b1;
                    espera_d  = '0;
                    if (opr[2] && opr[1]) begin
                        erro_d = 1'b1;
                    end
                end
            end
            StCheio: begin
                if (espera_q != LIMITE_W) begin
                    espera_d = espera_q + 1'b1;
                end
                if (LIMITE_ESPERA != 0 && espera_d == LIMITE_W) begin
                    timeout_d = 1'b1;
                end
                if (opr == 3'b000 && !ack_in) begin
                    estado_d  = StVazio;
                    res_d     = '0;
                    of_d      = DrNull;
                    neg_d     = DrNull;
                    zero_d    = DrNull;
                    ack_out_d = 1'b1;
                end
            end
            default: estado_d = StVazio;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            estado_q  <= StVazio;
            res_q     <= '0;
            of_q      <= DrNull;
            neg_q     <= DrNull;
            zero_q    <= DrNull;
            ack_out_q <= 1'b1;
            erro_q    <= 1'b0;
            timeout_q <= 1'b0;
            tokens_q  <= '0;
            espera_q  <= '0;
        end else begin
            estado_q  <= estado_d;
            res_q     <= res_d;
            of_q      <= of_d;
            neg_q     <= neg_d;
            zero_q    <= zero_d;
            ack_out_q <= ack_out_d;
            erro_q    <= erro_d;
            timeout_q <= timeout_d;
            tokens_q  <= tokens_d;
            espera_q  <= espera_d;
        end
    end

    assign resultado = res_q;
    assign of        = of_q;
    assign neg       = neg_q;
    assign zero      = zero_q;
    assign ack_out   = ack_out_q;
    assign erro      = erro_q;
    assign timeout   = timeout_q;
    assign tokens    = tokens_q;

endmodule
